// File: rtl/dsp_axis_pkg.sv
// Shared definitions for the round-robin AXI-Stream operand arbiter:
// operand packing, arbiter state encoding and the rotating priority pick.
package dsp_axis_pkg;

  localparam int MAX_REQ   = 8;
  localparam int MAX_IDX_W = 3;

  // Operand order inside a requester slice, a in the LSBs
  localparam int OPER_A = 0;
  localparam int OPER_B = 1;
  localparam int OPER_C = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  function automatic int oper_lsb(input int oper, input int data_w);
    return oper * data_w;
  endfunction

  // First set bit of valid_vec searching upward from last_grant+1, wrapping at num_req
  function automatic logic [MAX_IDX_W-1:0] rr_pick(input logic [MAX_REQ-1:0] valid_vec,
                                                   input logic [MAX_IDX_W-1:0] last_grant,
                                                   input int num_req);
    logic [MAX_IDX_W-1:0] pick;
    logic found;
    int idx;
    pick  = '0;
    found = 1'b0;
    for (int off = 1; off <= MAX_REQ; off++) begin
      idx = (int'(last_grant) + off) % num_req;
      if (off <= num_req && !found && valid_vec[idx]) begin
        pick  = MAX_IDX_W'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/dsp_axis_rr_arbiter_pick.sv
// Combinational rotate-and-priority-encode: one-hot grant plus index of the
// next requester after last_grant_i.
module rr_priority_pick
  import dsp_axis_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int ID_WIDTH = 2
) (
  input  logic [NUM_REQ-1:0]  req_vec_i,
  input  logic [ID_WIDTH-1:0] last_grant_i,
  output logic                any_o,
  output logic [NUM_REQ-1:0]  grant_oh_o,
  output logic [ID_WIDTH-1:0] grant_idx_o
);

  logic [MAX_IDX_W-1:0] pick;

  assign pick        = rr_pick(MAX_REQ'(req_vec_i), MAX_IDX_W'(last_grant_i), NUM_REQ);
  assign any_o       = |req_vec_i;
  assign grant_idx_o = ID_WIDTH'(pick);
  assign grant_oh_o  = any_o ? (NUM_REQ'(1) << pick) : '0;

endmodule

// File: rtl/dsp_axis_rr_arbiter.sv
// Packet-granular round-robin arbiter feeding a three-operand AXI-Stream DSP
// through a one-entry output register; grant_id tags each buffered beat.
module dsp_axis_rr_arbiter
  import dsp_axis_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REQ    = 4,
  parameter int ID_WIDTH   = 2
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_REQ*3*DATA_WIDTH-1:0]   s_req_data,
  input  logic [NUM_REQ-1:0]                s_req_valid,
  input  logic [NUM_REQ-1:0]                s_req_last,
  output logic [NUM_REQ-1:0]                s_req_ready,
  output logic [DATA_WIDTH-1:0]             m_axis_data_a,
  output logic [DATA_WIDTH-1:0]             m_axis_data_b,
  output logic [DATA_WIDTH-1:0]             m_axis_data_c,
  output logic                              m_axis_valid_a,
  output logic                              m_axis_valid_b,
  output logic                              m_axis_valid_c,
  output logic                              m_axis_last_a,
  output logic                              m_axis_last_b,
  output logic                              m_axis_last_c,
  input  logic                              m_axis_ready_a,
  input  logic                              m_axis_ready_b,
  input  logic                              m_axis_ready_c,
  output logic [ID_WIDTH-1:0]               grant_id,
  output logic                              busy
);

  localparam int BEAT_W = 3 * DATA_WIDTH;
  localparam int A_LSB  = oper_lsb(OPER_A, DATA_WIDTH);
  localparam int B_LSB  = oper_lsb(OPER_B, DATA_WIDTH);
  localparam int C_LSB  = oper_lsb(OPER_C, DATA_WIDTH);

  arb_state_t           state_q, state_d;
  logic [NUM_REQ-1:0]   owner_oh_q, owner_oh_d;
  logic [ID_WIDTH-1:0]  owner_id_q, owner_id_d;
  logic [ID_WIDTH-1:0]  last_grant_q, last_grant_d;
  logic [ID_WIDTH-1:0]  grant_id_q, grant_id_d;
  logic                 out_valid_q, out_valid_d;
  logic                 out_last_q, out_last_d;
  logic [BEAT_W-1:0]    out_beat_q, out_beat_d;

  logic                 pick_any;
  logic [NUM_REQ-1:0]   pick_oh;
  logic [ID_WIDTH-1:0]  pick_idx;
  logic                 accept, space, load, sel_last;
  logic [BEAT_W-1:0]    sel_beat;
  logic [NUM_REQ-1:0]   ready;

  rr_priority_pick #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_pick (
    .req_vec_i    (s_req_valid),
    .last_grant_i (last_grant_q),
    .any_o        (pick_any),
    .grant_oh_o   (pick_oh),
    .grant_idx_o  (pick_idx)
  );

  // A beat leaves only when all three DSP streams take it together
  assign accept = out_valid_q & m_axis_ready_a & m_axis_ready_b & m_axis_ready_c;
  assign space  = ~out_valid_q | accept;
  assign ready  = (state_q == BURST && space) ? owner_oh_q : '0;
  assign load   = |(s_req_valid & ready);

  always_comb begin
    sel_beat = '0;
    sel_last = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner_oh_q[i]) begin
        sel_beat = s_req_data[i*BEAT_W +: BEAT_W];
        sel_last = s_req_last[i];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_oh_d   = owner_oh_q;
    owner_id_d   = owner_id_q;
    last_grant_d = last_grant_q;
    grant_id_d   = grant_id_q;
    out_valid_d  = out_valid_q;
    out_last_d   = out_last_q;
    out_beat_d   = out_beat_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d      = BURST;
          owner_oh_d   = pick_oh;
          owner_id_d   = pick_idx;
          last_grant_d = pick_idx;
        end
      end
      BURST: begin
        if (load && sel_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      out_valid_d = 1'b1;
      out_beat_d  = sel_beat;
      out_last_d  = sel_last;
      grant_id_d  = owner_id_q;
    end else if (accept) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      owner_oh_q   <= '0;
      owner_id_q   <= '0;
      last_grant_q <= ID_WIDTH'(NUM_REQ - 1);
      grant_id_q   <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      out_beat_q   <= '0;
    end else begin
      state_q      <= state_d;
      owner_oh_q   <= owner_oh_d;
      owner_id_q   <= owner_id_d;
      last_grant_q <= last_grant_d;
      grant_id_q   <= grant_id_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
      out_beat_q   <= out_beat_d;
    end
  end

  assign s_req_ready    = ready;
  assign m_axis_data_a  = out_beat_q[A_LSB +: DATA_WIDTH];
  assign m_axis_data_b  = out_beat_q[B_LSB +: DATA_WIDTH];
  assign m_axis_data_c  = out_beat_q[C_LSB +: DATA_WIDTH];
  assign m_axis_valid_a = out_valid_q;
  assign m_axis_valid_b = out_valid_q;
  assign m_axis_valid_c = out_valid_q;
  assign m_axis_last_a  = out_last_q;
  assign m_axis_last_b  = out_last_q;
  assign m_axis_last_c  = out_last_q;
  assign grant_id       = grant_id_q;
  assign busy           = (state_q == BURST) | out_valid_q;

endmodule

// File: tb/tb_dsp_axis_rr_arbiter.sv
// Bench for dsp_axis_rr_arbiter: cycle table for directed corner cases, then
// round-robin and randomized traffic against a transaction-level model.
module tb_dsp_axis_rr_arbiter;

  localparam int DW = 16;
  localparam int NR = 4;
  localparam int IW = 2;
  localparam int BW = 3 * DW;

  logic              clk = 1'b0;
  logic              reset;
  logic [NR*BW-1:0]  s_req_data;
  logic [NR-1:0]     s_req_valid, s_req_last, s_req_ready;
  logic [DW-1:0]     mda, mdb, mdc;
  logic              mva, mvb, mvc, mla, mlb, mlc;
  logic              rdy_a, rdy_b, rdy_c;
  logic [IW-1:0]     grant_id;
  logic              busy;

  dsp_axis_rr_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .ID_WIDTH(IW)) dut (
    .clk(clk), .reset(reset),
    .s_req_data(s_req_data), .s_req_valid(s_req_valid), .s_req_last(s_req_last),
    .s_req_ready(s_req_ready),
    .m_axis_data_a(mda), .m_axis_data_b(mdb), .m_axis_data_c(mdc),
    .m_axis_valid_a(mva), .m_axis_valid_b(mvb), .m_axis_valid_c(mvc),
    .m_axis_last_a(mla), .m_axis_last_b(mlb), .m_axis_last_c(mlc),
    .m_axis_ready_a(rdy_a), .m_axis_ready_b(rdy_b), .m_axis_ready_c(rdy_c),
    .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- directed cycle table ----------------
  typedef struct {
    logic        rst;
    logic [3:0]  vld, lst;
    logic [15:0] a, b, c;
    logic [2:0]  rdy;
    logic [3:0]  e_rdy;
    logic        e_mv, e_busy, chk;
    logic [15:0] ea, eb, ec;
    logic        e_last;
    logic [1:0]  e_gid;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic rst, input logic [3:0] vld, input logic [3:0] lst,
                              input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                              input logic [2:0] rdy, input logic [3:0] e_rdy,
                              input logic e_mv, input logic e_busy, input logic ck,
                              input logic [15:0] ea, input logic [15:0] eb, input logic [15:0] ec,
                              input logic e_last, input logic [1:0] e_gid);
    vec_t v;
    v.rst = rst; v.vld = vld; v.lst = lst; v.a = a; v.b = b; v.c = c; v.rdy = rdy;
    v.e_rdy = e_rdy; v.e_mv = e_mv; v.e_busy = e_busy; v.chk = ck;
    v.ea = ea; v.eb = eb; v.ec = ec; v.e_last = e_last; v.e_gid = e_gid;
    return v;
  endfunction

  // ---------------- randomized traffic + model ----------------
  typedef struct {
    logic [BW-1:0] d;
    logic          l;
    logic [1:0]    id;
  } beat_t;

  int            mode;
  int            cyc;
  int            nbeats;
  logic [BW-1:0] r_data [NR];
  logic [NR-1:0] r_valid, r_last, hs_cap;
  int            r_left [NR];
  beat_t         sb[$];
  logic          m_idle;
  int            m_owner, m_last_grant;
  int            starts[$];
  int            prev_hs;
  logic          prev_hs_last, have_prev;

  function automatic int rr(input logic [NR-1:0] v, input int last);
    for (int k = 1; k <= NR; k++)
      if (v[(last + k) % NR]) return (last + k) % NR;
    return last;
  endfunction

  task automatic monitor();
    logic       acc;
    logic [3:0] exp_rdy;
    beat_t      e;
    cyc++;
    chk("valid_lockstep", {mvb, mvc}, {mva, mva});
    chk("last_lockstep", {mlb, mlc}, {mla, mla});
    acc = mva & rdy_a & rdy_b & rdy_c;
    if (acc) begin
      if (sb.size() == 0) chk("spurious_beat", 1, 0);
      else begin
        e = sb.pop_front();
        nbeats++;
        chk("beat_data", {mdc, mdb, mda}, e.d);
        chk("beat_last", mla, e.l);
        chk("beat_gid", grant_id, e.id);
      end
    end
    exp_rdy = '0;
    if (!m_idle && (!mva || acc)) exp_rdy[m_owner] = 1'b1;
    chk("req_ready", s_req_ready, exp_rdy);
    chk("busy", busy, !m_idle || mva);
    if (m_idle) begin
      if (|s_req_valid) begin
        m_owner      = rr(s_req_valid, m_last_grant);
        m_last_grant = m_owner;
        m_idle       = 1'b0;
      end
    end else if (s_req_valid[m_owner] && exp_rdy[m_owner]) begin
      e.d  = s_req_data[m_owner*BW +: BW];
      e.l  = s_req_last[m_owner];
      e.id = 2'(m_owner);
      sb.push_back(e);
      if (prev_hs_last || !have_prev) starts.push_back(m_owner);
      if (mode == 0 && have_prev) chk("hs_gap", cyc - prev_hs, prev_hs_last ? 2 : 1);
      have_prev    = 1'b1;
      prev_hs      = cyc;
      prev_hs_last = s_req_last[m_owner];
      if (s_req_last[m_owner]) m_idle = 1'b1;
    end
    hs_cap = s_req_valid & s_req_ready;
  endtask

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      if (hs_cap[i]) begin
        r_valid[i] = 1'b0;
        r_left[i]--;
      end
      if (r_left[i] == 0 && mode != 2 && (mode == 0 || $urandom_range(0, 3) == 0))
        r_left[i] = (mode == 0) ? 2 : int'($urandom_range(1, 4));
      if (!r_valid[i] && r_left[i] > 0 && (mode != 1 || $urandom_range(0, 2) != 0)) begin
        r_valid[i] = 1'b1;
        r_data[i]  = BW'({$urandom(), $urandom()});
        r_last[i]  = (r_left[i] == 1);
      end
      s_req_data[i*BW +: BW] = r_data[i];
    end
    s_req_valid = r_valid;
    s_req_last  = r_last;
    if (mode == 1) begin
      rdy_a = ($urandom_range(0, 3) != 0);
      rdy_b = ($urandom_range(0, 3) != 0);
      rdy_c = ($urandom_range(0, 3) != 0);
    end else begin
      rdy_a = 1'b1; rdy_b = 1'b1; rdy_c = 1'b1;
    end
  endtask

  task automatic restart();
    reset = 1'b1;
    r_valid = '0; r_last = '0; hs_cap = '0;
    for (int i = 0; i < NR; i++) begin r_left[i] = 0; r_data[i] = '0; end
    s_req_valid = '0; s_req_last = '0; s_req_data = '0;
    rdy_a = 1'b1; rdy_b = 1'b1; rdy_c = 1'b1;
    sb.delete(); starts.delete();
    m_idle = 1'b1; m_last_grant = NR - 1; m_owner = 0;
    have_prev = 1'b0; prev_hs_last = 1'b0; prev_hs = 0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic run_phase(input int md, input int n);
    mode = md;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      monitor();
      @(posedge clk); #1;
      drive();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_order[5];
    exp_order = '{0, 1, 2, 3, 0};
    cyc = 0; nbeats = 0;
    reset = 1'b1;
    s_req_valid = '0; s_req_last = '0; s_req_data = '0;
    rdy_a = 1'b1; rdy_b = 1'b1; rdy_c = 1'b1;

    // reset state
    tbl.push_back(mk(1, 4'b0000, 4'b0000,  0,  0,  0, 3'b111, 4'b0000, 0, 0, 1,  0,  0,  0, 0, 0));
    // requester 1, three beats
    tbl.push_back(mk(0, 4'b0010, 4'b0000,  1,  2,  5, 3'b111, 4'b0000, 0, 0, 0,  0,  0,  0, 0, 0));
    tbl.push_back(mk(0, 4'b0010, 4'b0000,  1,  2,  5, 3'b111, 4'b0010, 0, 1, 0,  0,  0,  0, 0, 0));
    tbl.push_back(mk(0, 4'b0010, 4'b0000,  2,  2,  5, 3'b111, 4'b0010, 1, 1, 1,  1,  2,  5, 0, 1));
    tbl.push_back(mk(0, 4'b0010, 4'b0010,  3,  2,  5, 3'b111, 4'b0010, 1, 1, 1,  2,  2,  5, 0, 1));
    tbl.push_back(mk(0, 4'b0000, 4'b0000,  0,  0,  0, 3'b111, 4'b0000, 1, 1, 1,  3,  2,  5, 1, 1));
    tbl.push_back(mk(0, 4'b0000, 4'b0000,  0,  0,  0, 3'b111, 4'b0000, 0, 0, 0,  0,  0,  0, 0, 0));
    // last_grant=1, only requester 0 valid, one-beat packet
    tbl.push_back(mk(0, 4'b0001, 4'b0001,  7,  8,  9, 3'b111, 4'b0000, 0, 0, 0,  0,  0,  0, 0, 0));
    tbl.push_back(mk(0, 4'b0001, 4'b0001,  7,  8,  9, 3'b111, 4'b0001, 0, 1, 0,  0,  0,  0, 0, 0));
    tbl.push_back(mk(0, 4'b0000, 4'b0000,  0,  0,  0, 3'b111, 4'b0000, 1, 1, 1,  7,  8,  9, 1, 0));
    tbl.push_back(mk(0, 4'b0000, 4'b0000,  0,  0,  0, 3'b111, 4'b0000, 0, 0, 0,  0,  0,  0, 0, 0));
    // requester 2 with ready_b low for three cycles
    tbl.push_back(mk(0, 4'b0100, 4'b0000, 10, 11, 12, 3'b111, 4'b0000, 0, 0, 0,  0,  0,  0, 0, 0));
    tbl.push_back(mk(0, 4'b0100, 4'b0000, 10, 11, 12, 3'b111, 4'b0100, 0, 1, 0,  0,  0,  0, 0, 0));
    for (int k = 0; k < 3; k++)
      tbl.push_back(mk(0, 4'b0100, 4'b0000, 20, 21, 22, 3'b101, 4'b0000, 1, 1, 1, 10, 11, 12, 0, 2));
    tbl.push_back(mk(0, 4'b0100, 4'b0000, 20, 21, 22, 3'b111, 4'b0100, 1, 1, 1, 10, 11, 12, 0, 2));
    tbl.push_back(mk(0, 4'b0100, 4'b0100, 30, 31, 32, 3'b111, 4'b0100, 1, 1, 1, 20, 21, 22, 0, 2));
    tbl.push_back(mk(0, 4'b0000, 4'b0000,  0,  0,  0, 3'b111, 4'b0000, 1, 1, 1, 30, 31, 32, 1, 2));
    tbl.push_back(mk(0, 4'b0000, 4'b0000,  0,  0,  0, 3'b111, 4'b0000, 0, 0, 0,  0,  0,  0, 0, 0));
    // owner 3 stalls four cycles while requester 2 waits
    tbl.push_back(mk(0, 4'b1100, 4'b0000, 40, 41, 42, 3'b111, 4'b0000, 0, 0, 0,  0,  0,  0, 0, 0));
    tbl.push_back(mk(0, 4'b1100, 4'b0000, 40, 41, 42, 3'b111, 4'b1000, 0, 1, 0,  0,  0,  0, 0, 0));
    tbl.push_back(mk(0, 4'b0100, 4'b0000, 40, 41, 42, 3'b111, 4'b1000, 1, 1, 1, 40, 41, 42, 0, 3));
    for (int k = 0; k < 3; k++)
      tbl.push_back(mk(0, 4'b0100, 4'b0000, 40, 41, 42, 3'b111, 4'b1000, 0, 1, 0,  0,  0,  0, 0, 0));
    tbl.push_back(mk(0, 4'b1100, 4'b1000, 50, 51, 52, 3'b111, 4'b1000, 0, 1, 0,  0,  0,  0, 0, 0));
    tbl.push_back(mk(0, 4'b0100, 4'b0000, 60, 61, 62, 3'b111, 4'b0000, 1, 1, 1, 50, 51, 52, 1, 3));
    tbl.push_back(mk(0, 4'b0100, 4'b0000, 60, 61, 62, 3'b111, 4'b0100, 0, 1, 0,  0,  0,  0, 0, 0));
    tbl.push_back(mk(0, 4'b0100, 4'b0000, 70, 71, 72, 3'b111, 4'b0100, 1, 1, 1, 60, 61, 62, 0, 2));
    // reset mid-burst, then requester 0 wins
    tbl.push_back(mk(1, 4'b0101, 4'b0000, 80, 81, 82, 3'b111, 4'b0000, 0, 0, 1,  0,  0,  0, 0, 0));
    tbl.push_back(mk(0, 4'b0101, 4'b0000, 80, 81, 82, 3'b111, 4'b0000, 0, 0, 0,  0,  0,  0, 0, 0));
    tbl.push_back(mk(0, 4'b0101, 4'b0000, 80, 81, 82, 3'b111, 4'b0001, 0, 1, 0,  0,  0,  0, 0, 0));
    tbl.push_back(mk(0, 4'b0000, 4'b0000,  0,  0,  0, 3'b111, 4'b0001, 1, 1, 1, 80, 81, 82, 0, 0));

    @(posedge clk); #1;
    foreach (tbl[k]) begin
      reset       = tbl[k].rst;
      s_req_valid = tbl[k].vld;
      s_req_last  = tbl[k].lst;
      s_req_data  = {NR{tbl[k].c, tbl[k].b, tbl[k].a}};
      rdy_a = tbl[k].rdy[0]; rdy_b = tbl[k].rdy[1]; rdy_c = tbl[k].rdy[2];
      @(negedge clk);
      chk($sformatf("row%0d_ready", k), s_req_ready, tbl[k].e_rdy);
      chk($sformatf("row%0d_valid", k), {mva, mvb, mvc}, {3{tbl[k].e_mv}});
      chk($sformatf("row%0d_busy", k), busy, tbl[k].e_busy);
      if (tbl[k].chk) begin
        chk($sformatf("row%0d_data", k), {mdc, mdb, mda}, {tbl[k].ec, tbl[k].eb, tbl[k].ea});
        chk($sformatf("row%0d_last", k), {mla, mlb, mlc}, {3{tbl[k].e_last}});
        chk($sformatf("row%0d_gid", k), grant_id, tbl[k].e_gid);
      end
      @(posedge clk); #1;
    end

    // all requesters busy with 2-beat packets
    restart();
    run_phase(0, 40);
    chk("rr_packets_seen", starts.size() >= 5, 1);
    if (starts.size() >= 5)
      for (int k = 0; k < 5; k++) chk($sformatf("rr_order%0d", k), starts[k], exp_order[k]);

    // random traffic, then drain
    restart();
    run_phase(1, 3000);
    run_phase(2, 300);
    chk("drain_scoreboard_empty", sb.size(), 0);
    chk("drain_requesters_idle", r_valid, 0);
    chk("random_beats_seen", nbeats > 200, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
